random_delay_injector: RTL and testbench

Multi-channel random-latency injector for the NPC memory/bus path. Each channel holds back a one-cycle trigger for a pseudo-random number of cycles after its request goes high. Downstream logic gates ready/valid with the trigger to stress the pipeline against variable memory latency. It generalises the fixed-period delay counter to N independent channels, with an LFSR-driven delay range, an abort rule and a bypass enable.

---
 rtl/rdi_pkg.sv | 32 +++
 rtl/rdi_lfsr16.sv | 34 +++
 rtl/random_delay_injector.sv | 103 ++++++++++
 tb/tb_random_delay_injector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rdi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rdi_pkg
//  Description : Shared types and constants for the random delay injector:
//                channel state encoding, LFSR geometry and the per-channel
//                rotate step used to decorrelate delay samples.
//  Revision    : 1.0 - initial release
// ============================================================================
package rdi_pkg;

    // Per-channel FSM state encoding
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } rdi_state_e;

    localparam int          c_LFSR_W    = 16;
    localparam logic [15:0] c_LFSR_MASK = 16'hB400;   // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam int          c_ROT_STEP  = 3;

    // Rotate a 16-bit word left by n positions (n taken modulo 16)
    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        logic [31:0] d;
        int          k;
        k = n % 16;
        d = {x, x};
        return d[31-k -: 16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rdi_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : rdi_lfsr16
//  Description : 16-bit Galois LFSR, free-running after reset. A zero seed
//                would lock the register at zero, so it is replaced by 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rdi_lfsr16
    import rdi_pkg::*;
#(
    parameter logic [15:0] SEED = c_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,        // synchronous, active-low
    output logic [15:0] o_state
);

    localparam logic [15:0] c_RST_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_state;

    // Load the guarded seed in reset, otherwise shift right and fold in the taps
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_RST_VAL;
        end else begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? c_LFSR_MASK : 16'h0000);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/random_delay_injector.sv
`default_nettype none
// ============================================================================
//  Module      : random_delay_injector
//  Description : N independent channels, each holding back a one-cycle
//                trigger for a pseudo-random number of cycles after its
//                request rises. Dropping the request aborts the wait.
//                Build option RDI_FIXED_DELAY_EN removes the LFSR and makes
//                every delay exactly MIN_DELAY (or 0 when en_i is low).
//  Revision    : 1.0 - initial release
// ============================================================================
module random_delay_injector
    import rdi_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          MIN_DELAY = 1,
    parameter int          RANGE_W   = 3,
    parameter logic [15:0] SEED      = c_LFSR_SEED
) (
    input  logic           clk,
    input  logic           rst,      // synchronous, active-low
    input  logic           en_i,
    input  logic [NCH-1:0] req_i,
    output logic [NCH-1:0] trig_o,
    output logic [NCH-1:0] busy_o
);

    // Wide enough for MIN_DELAY + 2^RANGE_W - 1 without wrapping
    localparam int c_CNT_W = $clog2(MIN_DELAY + (1 << RANGE_W));

`ifndef RDI_FIXED_DELAY_EN
    logic [15:0] w_lfsr;

    rdi_lfsr16 #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [RANGE_W-1:0] w_r;
        logic [c_CNT_W-1:0] w_delay;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        rdi_state_e         r_state;
        rdi_state_e         w_state_nxt;

`ifdef RDI_FIXED_DELAY_EN
        assign w_r = '0;
`else
        // Each channel looks at a differently rotated view of the LFSR
        assign w_r = RANGE_W'(rotl16(w_lfsr, c_ROT_STEP * gi));
`endif

        assign w_delay = en_i ? (c_CNT_W'(MIN_DELAY) + c_CNT_W'(w_r)) : '0;

        // Channel state and countdown register
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Arm on request, count down while held, release on handshake or abort
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                IDLE: begin
                    if (req_i[gi]) begin
                        w_state_nxt = ARMED;
                        w_cnt_nxt   = w_delay;
                    end
                end
                ARMED: begin
                    if (!req_i[gi]) begin
                        w_state_nxt = IDLE;       // abort: pending count dropped
                        w_cnt_nxt   = '0;
                    end else if (r_cnt != '0) begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = IDLE;       // trigger fires this cycle
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign trig_o[gi] = (r_state == ARMED) && (r_cnt == '0) && req_i[gi];
        assign busy_o[gi] = (r_state == ARMED);
    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_random_delay_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_random_delay_injector
//  Description : Self-checking bench for random_delay_injector (default,
//                random build). Main instance: NCH=2, MIN_DELAY=2, RANGE_W=3,
//                SEED=16'hACE1. Second instance uses SEED=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_random_delay_injector;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] req;
    logic [1:0] trig;
    logic [1:0] busy;
    logic       en_z;
    logic [0:0] req_z;
    logic [0:0] trig_z;
    logic [0:0] busy_z;

    int n_err = 0;
    int n_chk = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_z;

    random_delay_injector #(
        .NCH       (2),
        .MIN_DELAY (2),
        .RANGE_W   (3),
        .SEED      (16'hACE1)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .req_i  (req),
        .trig_o (trig),
        .busy_o (busy)
    );

    random_delay_injector #(
        .NCH       (1),
        .MIN_DELAY (0),
        .RANGE_W   (4),
        .SEED      (16'h0000)
    ) u_zs (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_z),
        .req_i  (req_z),
        .trig_o (trig_z),
        .busy_o (busy_z)
    );

    always #5 clk = ~clk;

    // Reference LFSRs: Galois, right shift, tap mask B400
    function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int slice_d(input logic [15:0] s, input int sh, input int mind, input int rw);
        logic [31:0] t;
        logic [15:0] rot;
        logic [15:0] msk;
        t   = {s, s};
        rot = t[31-sh -: 16];
        msk = (16'h0001 << rw) - 16'h0001;
        return mind + int'(rot & msk);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_lfsr   <= 16'hACE1;
            m_lfsr_z <= 16'h0001;
        end else begin
            m_lfsr   <= lfsr_nx(m_lfsr);
            m_lfsr_z <= lfsr_nx(m_lfsr_z);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] r);
        @(negedge clk);
        en  = e;
        req = r;
        #1;
    endtask

    // Both channels already armed at the coming edge; measure each delay.
    task automatic measure_pair(input logic e_mid, output int d0, output int d1);
        logic [1:0] rq;
        rq = 2'b11;
        d0 = -1;
        d1 = -1;
        for (int k = 1; k <= 24; k++) begin
            step(e_mid, rq);
            if (rq[0] && trig[0]) begin
                d0    = k - 1;
                rq[0] = 1'b0;
            end
            if (rq[1] && trig[1]) begin
                d1    = k - 1;
                rq[1] = 1'b0;
            end
            if (rq == 2'b00) break;
        end
        step(e_mid, 2'b00);
    endtask

    typedef struct {
        logic       en;
        logic [1:0] req;
        logic [1:0] trig;
        logic [1:0] busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int d0, d1, ed0, ed1, dz, ez;
        int hist0 [10];
        int hist1 [10];

        // Bypass vectors (en=0 gives D=0): inputs this cycle, outputs this cycle
        tbl[0] = '{1'b0, 2'b01, 2'b00, 2'b00};
        tbl[1] = '{1'b0, 2'b01, 2'b01, 2'b01};
        tbl[2] = '{1'b0, 2'b11, 2'b00, 2'b00};
        tbl[3] = '{1'b0, 2'b11, 2'b11, 2'b11};
        tbl[4] = '{1'b0, 2'b11, 2'b00, 2'b00};
        tbl[5] = '{1'b0, 2'b10, 2'b10, 2'b11};  // ch0 aborts, ch1 fires
        tbl[6] = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[7] = '{1'b0, 2'b00, 2'b00, 2'b00};
        for (int v = 0; v < 10; v++) begin
            hist0[v] = 0;
            hist1[v] = 0;
        end

        // ---- reset state, requests held high during reset ----
        rst   = 1'b0;
        en    = 1'b1;
        req   = 2'b11;
        en_z  = 1'b1;
        req_z = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_trig_z", int'(trig_z), 0);
        check("rst_busy_z", int'(busy_z), 0);

        // ---- zero seed: first sample after release uses LFSR=1 -> D=1 ----
        rst   = 1'b1;
        req   = 2'b00;
        @(negedge clk); #1;
        check("zs_busy_k1", int'(busy_z), 1);
        check("zs_trig_k1", int'(trig_z), 0);
        @(negedge clk); #1;
        check("zs_trig_k2", int'(trig_z), 1);
        req_z = 1'b0;
        @(negedge clk); #1;
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            req_z = 1'b1;
            #1;
            ez = int'(m_lfsr_z[3:0]);
            dz = -1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk); #1;
                if (trig_z[0]) begin
                    dz = k - 1;
                    break;
                end
            end
            req_z = 1'b0;
            check("zs_delay", dz, ez);
            @(negedge clk); #1;
        end

        // ---- bypass table ----
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].en, tbl[i].req);
            check($sformatf("tbl%0d_trig", i), int'(trig), int'(tbl[i].trig));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
        end

        // ---- random range: both channels, en dropped mid-count on odd runs ----
        for (int it = 0; it < 100; it++) begin
            step(1'b1, 2'b11);
            ed0 = slice_d(m_lfsr, 0, 2, 3);
            ed1 = slice_d(m_lfsr, 3, 2, 3);
            measure_pair(it[0] ? 1'b0 : 1'b1, d0, d1);
            check("rand_d0", d0, ed0);
            check("rand_d1", d1, ed1);
            check("rand_rng0", int'(d0 >= 2 && d0 <= 9), 1);
            check("rand_rng1", int'(d1 >= 2 && d1 <= 9), 1);
            if (d0 >= 0 && d0 <= 9) hist0[d0]++;
            if (d1 >= 0 && d1 <= 9) hist1[d1]++;
        end
        for (int v = 2; v <= 9; v++) begin
            check($sformatf("cover0_d%0d", v), int'(hist0[v] > 0), 1);
            check($sformatf("cover1_d%0d", v), int'(hist1[v] > 0), 1);
        end

        // ---- abort: req high 3 cycles, then low ----
        step(1'b1, 2'b01);
        step(1'b1, 2'b01);
        check("abort_busy_armed", int'(busy), 1);
        step(1'b1, 2'b01);
        check("abort_no_trig_a", int'(trig), 0);
        step(1'b1, 2'b00);
        check("abort_busy_fall", int'(busy), 1);
        check("abort_no_trig_b", int'(trig), 0);
        step(1'b1, 2'b00);
        check("abort_busy_idle", int'(busy), 0);
        step(1'b1, 2'b11);
        ed0 = slice_d(m_lfsr, 0, 2, 3);
        ed1 = slice_d(m_lfsr, 3, 2, 3);
        measure_pair(1'b1, d0, d1);
        check("abort_restart_d0", d0, ed0);
        check("abort_restart_d1", d1, ed1);

        // ---- reset mid-count ----
        step(1'b1, 2'b01);
        step(1'b1, 2'b01);
        check("mid_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(1'b1, 2'b01);
        check("mid_rst_trig", int'(trig), 0);
        check("mid_rst_busy", int'(busy), 0);
        // Arm both at the first edge after release: LFSR=ACE1 -> D0=3, D1=7
        rst = 1'b1;
        en  = 1'b1;
        req = 2'b11;
        measure_pair(1'b1, d0, d1);
        check("post_rst_d0", d0, 3);
        check("post_rst_d1", d1, 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
